serial_magnitude_comparator: RTL and testbench

Multi-cycle magnitude comparator for wide unsigned operands. It uses the same LSB-first cascade (less/equal/greater) rule as the team's 4-bit comparator slices, but evaluates one nibble per clock instead of a combinational chain. It sits between a valid/ready operand source and any consumer of a one-hot lt/eq/gt result. It trades latency for area and timing on wide buses.

---
 rtl/serial_magnitude_comparator.sv | 134 +++++++++++++
 tb/tb_serial_magnitude_comparator.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/serial_magnitude_comparator.sv
// Compares two wide unsigned operands one nibble per clock, least significant nibble first.
// Higher nibbles override lower ones, so the final cascade state gives the full-width ordering.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand pair
// RUN   | one nibble compared per edge, idx counts 0..NIBBLES-1
// DONE  | one-hot lt/eq/gt and msd_idx held until out_ready
module serial_magnitude_comparator #(
    parameter int WIDTH   = 32,
    parameter int NIBBLES = WIDTH / 4,
    parameter int IW      = $clog2(NIBBLES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          lt,
    output logic          eq,
    output logic          gt,
    output logic [IW-1:0] msd_idx
);

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
            $error("serial_magnitude_comparator: WIDTH must be a multiple of 4 and >= 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    state_t          state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   msd_q, msd_d;
    logic            lt_q, lt_d;
    logic            eq_q, eq_d;
    logic            gt_q, gt_d;
    logic [3:0]      na, nb;

    // Shift rather than part-select keeps the index arithmetic width-clean for any WIDTH.
    assign na = 4'(a_q >> {idx_q, 2'b00});
    assign nb = 4'(b_q >> {idx_q, 2'b00});

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        msd_d   = msd_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    lt_d    = 1'b0;
                    eq_d    = 1'b1;
                    gt_d    = 1'b0;
                    idx_d   = '0;
                    msd_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (na > nb) begin
                    lt_d  = 1'b0;
                    eq_d  = 1'b0;
                    gt_d  = 1'b1;
                    msd_d = idx_q;
                end else if (na < nb) begin
                    lt_d  = 1'b1;
                    eq_d  = 1'b0;
                    gt_d  = 1'b0;
                    msd_d = idx_q;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                // Result registers are left alone on exit; consumers qualify with out_valid.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            msd_q   <= '0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            msd_q   <= msd_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign lt        = lt_q;
    assign eq        = eq_q;
    assign gt        = gt_q;
    assign msd_idx   = msd_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Self-checking bench: directed cases plus random operand pairs checked against an
// arithmetic reference (full-width compare, top-down search for the first differing nibble).
module tb_serial_magnitude_comparator;

    localparam int W  = 32;
    localparam int N  = W / 4;
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          lt, eq, gt;
    logic [IW-1:0] msd_idx;

    int n_checks = 0;
    int n_fail   = 0;

    serial_magnitude_comparator #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .lt        (lt),
        .eq        (eq),
        .gt        (gt),
        .msd_idx   (msd_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  output logic el, output logic ee, output logic eg,
                                  output int em);
        el = (ma < mb);
        ee = (ma == mb);
        eg = (ma > mb);
        em = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (((ma >> (4 * i)) & 32'hF) != ((mb >> (4 * i)) & 32'hF)) begin
                em = i;
                break;
            end
        end
    endfunction

    // Called at a negedge with the DUT idle. Optionally scrambles inputs during RUN,
    // holds out_ready low for 'hold' cycles, and may present a pending operand meanwhile.
    task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input int hold,
                         input bit scramble, input bit pend,
                         input logic [W-1:0] pa, input logic [W-1:0] pb);
        logic el, ee, eg;
        int   em;
        int   cnt;
        bit   seen;
        model(oa, ob, el, ee, eg, em);
        chk("idle_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        a = oa;
        b = ob;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("accept_ready_low", 64'(in_ready), 64'd0);
        cnt  = 0;
        seen = 0;
        for (int k = 0; k < N + 4; k++) begin
            if (scramble) begin
                a = $urandom;
                b = $urandom;
                in_valid = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            cnt++;
            @(negedge clk);
            if (out_valid) begin
                seen = 1;
                break;
            end
        end
        chk("out_valid_seen", 64'(seen), 64'd1);
        chk("latency", 64'(cnt), 64'(N));
        in_valid = 1'b0;
        if (pend) begin
            in_valid = 1'b1;
            a = pa;
            b = pb;
        end
        chk("lt", 64'(lt), 64'(el));
        chk("eq", 64'(eq), 64'(ee));
        chk("gt", 64'(gt), 64'(eg));
        chk("msd_idx", 64'(msd_idx), 64'(em));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_ready", 64'(in_ready), 64'd0);
            chk("hold_result", 64'({lt, eq, gt}), 64'({el, ee, eg}));
            chk("hold_msd", 64'(msd_idx), 64'(em));
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_valid", 64'(out_valid), 64'd0);
        chk("release_ready", 64'(in_ready), 64'd1);
        chk("kept_result", 64'({lt, eq, gt}), 64'({el, ee, eg}));
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        bit           no_valid;
        // reset state
        #12;
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_res", 64'({lt, eq, gt}), 64'd0);
        chk("rst_msd", 64'(msd_idx), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // reset mid-RUN
        in_valid = 1'b1;
        a = 32'd1;
        b = 32'd2;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", 64'(in_ready), 64'd1);
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_res", 64'({lt, eq, gt}), 64'd0);
        chk("midrst_msd", 64'(msd_idx), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        no_valid = 1;
        repeat (N + 4) begin
            @(negedge clk);
            if (out_valid) no_valid = 0;
        end
        chk("midrst_no_result", 64'(no_valid), 64'd1);

        // directed cases
        do_op(32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, '0, '0);
        do_op(32'h1000_0000, 32'h0FFF_FFFF, 0, 0, 0, '0, '0);
        do_op(32'h0FFF_FFFF, 32'h1000_0000, 0, 0, 0, '0, '0);
        do_op(32'h0000_0005, 32'h0000_0003, 0, 0, 0, '0, '0);
        do_op(32'h0000_0010, 32'h0000_0011, 0, 0, 0, '0, '0);
        do_op(32'h1234_5678, 32'h1234_5679, 5, 0, 1, 32'h8000_0001, 32'h8000_0002);
        do_op(32'h8000_0001, 32'h8000_0002, 0, 0, 0, '0, '0);
        do_op(32'hFFFF_FFFF, 32'h0000_0000, 1, 1, 0, '0, '0);

        // random operand pairs, biased to share upper nibbles or be equal
        for (int r = 0; r < 40; r++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = (ra & 32'hFFFF_0000) | (rb & 32'h0000_FFFF);
                2: rb = ra ^ (32'h1 << $urandom_range(0, 31));
                default: ;
            endcase
            do_op(ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0, '0, '0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
